// File: rtl/reg_bank_ctrl.sv
// rtl/reg_bank_ctrl.sv - instruction sequencer driving reg16 read selects, ALU start and write enables
`timescale 1ns/1ps

module reg_bank_ctrl #(
    parameter int NREG  = 16,
    parameter int IDX_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [15:0]     instr,
    output logic            instr_ready,
    output logic            alu_go,
    output logic [3:0]      alu_op,
    input  logic            alu_done,
    output logic [NREG-1:0] selA,
    output logic [NREG-1:0] selB,
    output logic [NREG-1:0] en,
    output logic            busy,
    output logic            halted
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        READ   = 3'd2,
        EXEC   = 3'd3,
        WRITE  = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_CMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      r_state;
    logic [15:0] r_instr;

    logic [3:0]       w_op;
    logic [IDX_W-1:0] w_rd;
    logic [IDX_W-1:0] w_rs;
    logic [IDX_W-1:0] w_rt;

    assign w_op = r_instr[15:12];
    assign w_rd = r_instr[8 +: IDX_W];
    assign w_rs = r_instr[4 +: IDX_W];
    assign w_rt = r_instr[0 +: IDX_W];

    // Indices beyond the bank decode to no select at all.
    function automatic logic [NREG-1:0] f_onehot(input logic [IDX_W-1:0] idx);
        if (int'(idx) < NREG)
            return {{(NREG-1){1'b0}}, 1'b1} << idx;
        else
            return '0;
    endfunction

    // Every output is assigned alongside the state it belongs to, so each is a flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_instr     <= '0;
            instr_ready <= 1'b1;
            alu_go      <= 1'b0;
            alu_op      <= '0;
            selA        <= '0;
            selB        <= '0;
            en          <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        r_instr     <= instr;
                        r_state     <= DECODE;
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                DECODE: begin
                    if (w_op == OP_NOP) begin
                        r_state     <= IDLE;
                        instr_ready <= 1'b1;
                        busy        <= 1'b0;
                    end else if (w_op == OP_HALT) begin
                        r_state <= HALT;
                        busy    <= 1'b0;
                        halted  <= 1'b1;
                    end else begin
                        r_state <= READ;
                        selA    <= f_onehot(w_rs);
                        selB    <= f_onehot(w_rt);
                        alu_go  <= 1'b1;
                        alu_op  <= w_op;
                    end
                end
                READ: begin
                    r_state <= EXEC;
                    alu_go  <= 1'b0;
                end
                EXEC: begin
                    if (alu_done) begin
                        selA   <= '0;
                        selB   <= '0;
                        alu_op <= '0;
                        if (w_op == OP_CMP) begin
                            r_state     <= IDLE;
                            instr_ready <= 1'b1;
                            busy        <= 1'b0;
                        end else begin
                            r_state <= WRITE;
                            en      <= f_onehot(w_rd);
                        end
                    end
                end
                WRITE: begin
                    r_state     <= IDLE;
                    en          <= '0;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state     <= IDLE;
                    instr_ready <= 1'b1;
                    alu_go      <= 1'b0;
                    alu_op      <= '0;
                    selA        <= '0;
                    selB        <= '0;
                    en          <= '0;
                    busy        <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// tb/tb_reg_bank_ctrl.sv - self-checking bench for reg_bank_ctrl against a cycle-timeline model
`timescale 1ns/1ps

module tb_reg_bank_ctrl;

    localparam int NR = 12;
    localparam int OW = 8 + 3 * NR;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          instr_valid = 1'b0;
    logic [15:0]   instr = '0;
    logic          alu_done = 1'b0;
    logic          instr_ready;
    logic          alu_go;
    logic [3:0]    alu_op;
    logic [NR-1:0] selA;
    logic [NR-1:0] selB;
    logic [NR-1:0] en;
    logic          busy;
    logic          halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_bank_ctrl #(.NREG(NR), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .alu_go(alu_go), .alu_op(alu_op),
        .alu_done(alu_done), .selA(selA), .selB(selB), .en(en),
        .busy(busy), .halted(halted)
    );

    localparam logic [OW-1:0] RESET_VEC = {1'b1, {(OW-1){1'b0}}};

    function automatic logic [OW-1:0] obs();
        return {instr_ready, busy, halted, alu_go, alu_op, selA, selB, en};
    endfunction

    function automatic logic [NR-1:0] oh(input int idx);
        logic [NR-1:0] v;
        v = '0;
        if (idx < NR) v[idx] = 1'b1;
        return v;
    endfunction

    // Expected outputs k cycles after the handshake cycle (k=0), with d EXEC cycles of alu_done low.
    function automatic logic [OW-1:0] model_at(input logic [15:0] ins, input int d, input int k);
        logic r, b, h, g;
        logic [3:0] o, op;
        logic [NR-1:0] a, bb, e;
        r = 0; b = 0; h = 0; g = 0; o = 0; a = 0; bb = 0; e = 0;
        op = ins[15:12];
        if (k == 0) r = 1;
        else if (k == 1) b = 1;
        else if (op == 4'h0) r = 1;
        else if (op == 4'hF) h = 1;
        else if (k <= 3 + d) begin
            b = 1; g = (k == 2); o = op;
            a = oh(int'(ins[7:4])); bb = oh(int'(ins[3:0]));
        end else if (k == 4 + d && op != 4'hE) begin
            b = 1; e = oh(int'(ins[11:8]));
        end else r = 1;
        return {r, b, h, g, o, a, bb, e};
    endfunction

    function automatic int last_k(input logic [15:0] ins, input int d);
        if (ins[15:12] == 4'h0) return 2;
        if (ins[15:12] == 4'hE) return 4 + d;
        return 5 + d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (obs() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset got=%h exp=%h", obs(), RESET_VEC);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] ins = 16'h1312;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) step();
            instr = ins; instr_valid = (k < 5); alu_done = 1'b1;
            checks++;
            if (obs() !== model_at(ins, 0, k)) begin
                errors++;
                $display("FAIL basic k=%0d got=%h exp=%h", k, obs(), model_at(ins, 0, k));
            end
        end
        instr_valid = 1'b0; alu_done = 1'b0;
    endtask

    task automatic test_wait();
        logic [15:0] ins = 16'h2555;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) step();
            instr = ins; instr_valid = (k == 0); alu_done = (k == 6);
            checks++;
            if (obs() !== model_at(ins, 3, k)) begin
                errors++;
                $display("FAIL wait k=%0d got=%h exp=%h", k, obs(), model_at(ins, 3, k));
            end
        end
        alu_done = 1'b0;
    endtask

    task automatic test_cmp();
        logic [15:0] ins = 16'hE0AB;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) step();
            instr = ins; instr_valid = (k == 0); alu_done = (k == 4);
            checks++;
            if (obs() !== model_at(ins, 1, k)) begin
                errors++;
                $display("FAIL cmp k=%0d got=%h exp=%h", k, obs(), model_at(ins, 1, k));
            end
        end
        alu_done = 1'b0;
    endtask

    task automatic test_nop();
        logic [15:0] ins = 16'h0000;
        for (int k = 0; k <= 2; k++) begin
            if (k > 0) step();
            instr = ins; instr_valid = (k == 0); alu_done = 1'b1;
            checks++;
            if (obs() !== model_at(ins, 0, k)) begin
                errors++;
                $display("FAIL nop k=%0d got=%h exp=%h", k, obs(), model_at(ins, 0, k));
            end
        end
        alu_done = 1'b0;
    endtask

    task automatic test_halt();
        logic [15:0] ins = 16'hF000;
        for (int k = 0; k <= 2; k++) begin
            if (k > 0) step();
            instr = ins; instr_valid = (k == 0);
            checks++;
            if (obs() !== model_at(ins, 0, k)) begin
                errors++;
                $display("FAIL halt k=%0d got=%h exp=%h", k, obs(), model_at(ins, 0, k));
            end
        end
        for (int i = 0; i < 5; i++) begin
            instr = 16'h1312; instr_valid = 1'($urandom_range(0, 1)); alu_done = 1'b1;
            step();
            checks++;
            if (obs() !== model_at(ins, 0, 2)) begin
                errors++;
                $display("FAIL halt_sticky i=%0d got=%h exp=%h", i, obs(), model_at(ins, 0, 2));
            end
        end
        instr_valid = 1'b0; alu_done = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++;
        if (obs() !== RESET_VEC) begin
            errors++;
            $display("FAIL halt_reset got=%h exp=%h", obs(), RESET_VEC);
        end
        step();
        checks++;
        if (obs() !== RESET_VEC) begin
            errors++;
            $display("FAIL halt_idle got=%h exp=%h", obs(), RESET_VEC);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] ins = 16'h1312;
        logic [15:0] ins2 = 16'h3456;
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) step();
            instr = ins; instr_valid = (k == 0); alu_done = 1'b0;
            checks++;
            if (obs() !== model_at(ins, 5, k)) begin
                errors++;
                $display("FAIL mid k=%0d got=%h exp=%h", k, obs(), model_at(ins, 5, k));
            end
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++;
        if (obs() !== RESET_VEC) begin
            errors++;
            $display("FAIL mid_reset got=%h exp=%h", obs(), RESET_VEC);
        end
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) step();
            instr = ins2; instr_valid = (k == 0); alu_done = (k == 3);
            checks++;
            if (obs() !== model_at(ins2, 0, k)) begin
                errors++;
                $display("FAIL mid_after k=%0d got=%h exp=%h", k, obs(), model_at(ins2, 0, k));
            end
        end
        alu_done = 1'b0;
    endtask

    // Back-to-back random instructions: the closing IDLE cycle of one is the handshake of the next.
    task automatic test_back_to_back();
        logic [15:0] ins;
        int d, last;
        for (int n = 0; n < 30; n++) begin
            ins = {4'($urandom_range(0, 14)), 12'($urandom)};
            d = $urandom_range(0, 3);
            last = last_k(ins, d);
            for (int k = 0; k <= last; k++) begin
                if (k > 0) step();
                instr = (k == 0) ? ins : 16'($urandom);
                instr_valid = (k == 0) ? 1'b1 : (k == last) ? 1'b0 : 1'($urandom_range(0, 1));
                if (ins[15:12] != 4'h0 && k >= 3 && k <= 3 + d)
                    alu_done = (k == 3 + d);
                else
                    alu_done = 1'($urandom_range(0, 1));
                checks++;
                if (obs() !== model_at(ins, d, k)) begin
                    errors++;
                    $display("FAIL b2b n=%0d ins=%h d=%0d k=%0d got=%h exp=%h",
                             n, ins, d, k, obs(), model_at(ins, d, k));
                end
            end
        end
        instr_valid = 1'b0; alu_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait();
        test_cmp();
        test_nop();
        test_reset_mid();
        test_back_to_back();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
